// File: rtl/speles_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : speles_pkg
//  Brief    : Shared definitions for the number-game round timer
//  Revision : 1.0 - initial release
// ============================================================================
package speles_pkg;

    localparam int TIME_W = 5;

    localparam logic [1:0] ST_SVEICINATI = 2'd0;
    localparam logic [1:0] ST_GATAVS     = 2'd1;
    localparam logic [1:0] ST_MINESANA   = 2'd2;
    localparam logic [1:0] ST_ZAUDETS    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } taimeris_st_t;

    function automatic logic [1:0] bcd_tens_of(input int unsigned v);
        return 2'(v / 10);
    endfunction

    function automatic logic [3:0] bcd_ones_of(input int unsigned v);
        return 4'(v % 10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sekundes_dalitajs.sv
`default_nettype none
// ============================================================================
//  Module   : sekundes_dalitajs
//  Brief    : Seconds prescaler, one-cycle tick on each wrap to zero
//  Revision : 1.0 - initial release
// ============================================================================
module sekundes_dalitajs #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = en && !clr && (r_cnt == c_last);
    assign tick   = w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/speles_taimeris.sv
`default_nettype none
// ============================================================================
//  Module   : speles_taimeris
//  Brief    : Round countdown timer with binary and BCD remaining-time outputs
//  Revision : 1.0 - initial release
// ============================================================================
module speles_taimeris #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TIME_W        = speles_pkg::TIME_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        state,
    input  logic              set_f,
    input  logic [TIME_W-1:0] set_v,
    output logic              end_f,
    output logic [TIME_W-1:0] time_left,
    output logic [1:0]        bcd_tens,
    output logic [3:0]        bcd_ones,
    output logic              running,
    output logic              sec_pulse
);

    import speles_pkg::*;

    taimeris_st_t      r_fsm;
    taimeris_st_t      w_fsm_nxt;
    logic [1:0]        r_state_q;
    logic [TIME_W-1:0] w_time_nxt;
    logic              w_end_nxt;
    logic              w_pulse_nxt;
    logic              w_in_game;
    logic              w_entry;
    logic              w_load;
    logic              w_clr;
    logic              w_tick;

    assign w_in_game = (state == ST_MINESANA);
    assign w_entry   = w_in_game && (r_state_q != ST_MINESANA);
    assign w_load    = (r_fsm == IDLE) && w_entry && set_f;
    // Prescaler only runs inside a live round; any exit restarts it from zero.
    assign w_clr     = (r_fsm != RUN) || !w_in_game;
    assign running   = (r_fsm == RUN);

    sekundes_dalitajs #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_dalitajs (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (r_fsm == RUN),
        .tick (w_tick)
    );

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_time_nxt  = time_left;
        w_end_nxt   = end_f;
        w_pulse_nxt = 1'b0;
        case (r_fsm)
            IDLE: begin
                w_end_nxt = 1'b0;
                if (w_load) begin
                    if (set_v == '0) begin
                        w_fsm_nxt  = EXPIRED;
                        w_time_nxt = '0;
                        w_end_nxt  = 1'b1;
                    end else begin
                        w_fsm_nxt  = RUN;
                        w_time_nxt = set_v;
                    end
                end
            end
            RUN: begin
                // Leaving the guessing state beats a coincident final wrap.
                if (!w_in_game) begin
                    w_fsm_nxt = IDLE;
                end else if (w_tick) begin
                    w_time_nxt  = time_left - TIME_W'(1);
                    w_pulse_nxt = 1'b1;
                    if (time_left == TIME_W'(1)) begin
                        w_fsm_nxt = EXPIRED;
                        w_end_nxt = 1'b1;
                    end
                end
            end
            EXPIRED: begin
                w_time_nxt = '0;
                w_end_nxt  = 1'b1;
                // The lost state is the consequence of expiry, so the flag is held through it.
                if (state == ST_SVEICINATI || state == ST_GATAVS) begin
                    w_fsm_nxt = IDLE;
                    w_end_nxt = 1'b0;
                end
            end
            default: begin
                w_fsm_nxt = IDLE;
                w_end_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm     <= IDLE;
            r_state_q <= ST_SVEICINATI;
            time_left <= '0;
            bcd_tens  <= '0;
            bcd_ones  <= '0;
            end_f     <= 1'b0;
            sec_pulse <= 1'b0;
        end else begin
            r_fsm     <= w_fsm_nxt;
            r_state_q <= state;
            time_left <= w_time_nxt;
            bcd_tens  <= bcd_tens_of(32'(w_time_nxt));
            bcd_ones  <= bcd_ones_of(32'(w_time_nxt));
            end_f     <= w_end_nxt;
            sec_pulse <= w_pulse_nxt;
        end
    end

endmodule
`default_nettype wire
